// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : Two-way valid/ready stream demultiplexer. Each output is fed
//               through its own 2-entry {last,data} FIFO. Packet-locked
//               routing is built when STREAM_DEMUX_PKT_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    output logic             out2_last,
    input  logic             out2_ready,
    output logic             busy
);

    localparam int N_OUT   = 2;
    localparam int ENTRY_W = WIDTH + 1;

    logic                tgt_out1;
    logic                lock_open;
    logic [N_OUT-1:0]    push;
    logic [N_OUT-1:0]    pop;
    logic [N_OUT-1:0]    out_ready;
    logic [N_OUT-1:0]    out_valid;
    logic [1:0]          cnt  [N_OUT];
    logic [ENTRY_W-1:0]  head [N_OUT];

    // Index 0 is output 1, index 1 is output 2.
    assign out_ready = {out2_ready, out1_ready};
    assign in_ready  = tgt_out1 ? (cnt[0] != 2'd2) : (cnt[1] != 2'd2);
    assign push[0]   = in_valid & in_ready &  tgt_out1;
    assign push[1]   = in_valid & in_ready & ~tgt_out1;
    assign pop       = out_valid & out_ready;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK1 = 2'd1;
    localparam logic [1:0] ST_LOCK2 = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid && in_ready) begin
            if (in_last) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = sel ? ST_LOCK1 : ST_LOCK2;
            end
        end
    end

    always_comb begin
        tgt_out1  = sel;
        lock_open = 1'b0;
        case (state_q)
            ST_LOCK1: begin
                tgt_out1  = 1'b1;
                lock_open = 1'b1;
            end
            ST_LOCK2: begin
                tgt_out1  = 1'b0;
                lock_open = 1'b1;
            end
            default: begin
                tgt_out1  = sel;
                lock_open = 1'b0;
            end
        endcase
    end
`else
    assign tgt_out1  = sel;
    assign lock_open = 1'b0;
`endif

    for (genvar i = 0; i < N_OUT; i++) begin : g_fifo
        logic [ENTRY_W-1:0] mem_q [2];
        logic [ENTRY_W-1:0] mem_d [2];
        logic               wr_ptr_q;
        logic               wr_ptr_d;
        logic               rd_ptr_q;
        logic               rd_ptr_d;
        logic [1:0]         cnt_q;
        logic [1:0]         cnt_d;

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[i]) begin
                mem_d[wr_ptr_q] = {in_last, in_data};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop[i]) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[0] <= '0;
                mem_q[1] <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        assign cnt[i]       = cnt_q;
        assign head[i]      = mem_q[rd_ptr_q];
        assign out_valid[i] = (cnt_q != 2'd0);
    end

    assign out1_valid = out_valid[0];
    assign out1_data  = head[0][WIDTH-1:0];
    assign out1_last  = head[0][WIDTH];
    assign out2_valid = out_valid[1];
    assign out2_data  = head[1][WIDTH-1:0];
    assign out2_last  = head[1][WIDTH];
    assign busy       = out_valid[0] | out_valid[1] | lock_open;

endmodule
`default_nettype wire
